// File: rtl/mbus_tx_arbiter_pkg.sv
// rtl/mbus_tx_arbiter_pkg.sv - shared state and owner encodings for the MBus TX arbiter
package mbus_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_ACK    = 3'd2,
        ST_RESULT = 3'd3,
        ST_RESP   = 3'd4
    } arb_state_e;

    // One-hot grant as seen on arb_owner
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_R0   = 2'b01;
    localparam logic [1:0] OWN_R1   = 2'b10;

endpackage

// File: rtl/mbus_tx_rr_pick.sv
// rtl/mbus_tx_rr_pick.sv - combinational two-way winner pick, round-robin or fixed priority
module mbus_tx_rr_pick
    import mbus_tx_arbiter_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic [1:0] req_i,
    input  logic       rr_ptr_i,
    output logic [1:0] grant_o
);

    // rr_ptr_i = 1 favours r1 on a tie; only consulted when both request
    always_comb begin
        grant_o = OWN_NONE;
        if (req_i == 2'b11) begin
            grant_o = ((RR_EN != 0) && rr_ptr_i) ? OWN_R1 : OWN_R0;
        end else if (req_i[0]) begin
            grant_o = OWN_R0;
        end else if (req_i[1]) begin
            grant_o = OWN_R1;
        end
    end

endmodule

// File: rtl/mbus_tx_arbiter.sv
// rtl/mbus_tx_arbiter.sv - shares the MBus master TX port between two requesters with
// transaction-level grant locking and a response watchdog
module mbus_tx_arbiter
    import mbus_tx_arbiter_pkg::*;
#(
    parameter int RR_EN  = 1,
    parameter int TO_W   = 16,
    parameter int TO_CYC = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] r0_txaddr,
    input  logic [31:0] r0_txdata,
    input  logic        r0_txreq,
    input  logic        r0_txpend,
    output logic        r0_txack,
    output logic        r0_txsucc,
    output logic        r0_txfail,
    input  logic        r0_txresp_ack,
    input  logic [31:0] r1_txaddr,
    input  logic [31:0] r1_txdata,
    input  logic        r1_txreq,
    input  logic        r1_txpend,
    output logic        r1_txack,
    output logic        r1_txsucc,
    output logic        r1_txfail,
    input  logic        r1_txresp_ack,
    output logic [31:0] mbus_txaddr,
    output logic [31:0] mbus_txdata,
    output logic        mbus_txreq,
    output logic        mbus_txpend,
    input  logic        mbus_txack,
    input  logic        mbus_txsucc,
    input  logic        mbus_txfail,
    output logic        mbus_txresp_ack,
    output logic [1:0]  arb_owner,
    output logic        arb_timeout
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    arb_state_e      state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic            pend_q, pend_d;
    logic            rr_q, rr_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            synth_fail_q, synth_fail_d;
    logic            timeout_q, timeout_d;

    logic [1:0]      pick;
    logic            own_req, own_pend, own_resp_ack;
    logic            fwd, resp;

    mbus_tx_rr_pick #(.RR_EN(RR_EN)) u_pick (
        .req_i    ({r1_txreq, r0_txreq}),
        .rr_ptr_i (rr_q),
        .grant_o  (pick)
    );

    assign own_req      = (owner_q[0] & r0_txreq)      | (owner_q[1] & r1_txreq);
    assign own_pend     = (owner_q[0] & r0_txpend)     | (owner_q[1] & r1_txpend);
    assign own_resp_ack = (owner_q[0] & r0_txresp_ack) | (owner_q[1] & r1_txresp_ack);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            pend_q       <= 1'b0;
            rr_q         <= 1'b0;
            wd_q         <= '0;
            synth_fail_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            pend_q       <= pend_d;
            rr_q         <= rr_d;
            wd_q         <= wd_d;
            synth_fail_q <= synth_fail_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        pend_d       = pend_q;
        rr_d         = rr_q;
        wd_d         = '0;
        synth_fail_d = synth_fail_q;
        timeout_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick != OWN_NONE) begin
                    owner_d = pick;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mbus_txack) begin
                    pend_d  = own_pend;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!mbus_txack) begin
                    state_d = pend_q ? ST_REQ : ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (mbus_txsucc || mbus_txfail) begin
                    state_d = ST_RESP;
                end else if ((TO_CYC != 0) && (wd_q == TO_LAST)) begin
                    timeout_d    = 1'b1;
                    synth_fail_d = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_RESP: begin
                // A synthesized fail is held until the owner acknowledges it
                if (own_resp_ack) begin
                    synth_fail_d = 1'b0;
                end
                if (!mbus_txsucc && !mbus_txfail && !synth_fail_q && !own_resp_ack) begin
                    state_d      = ST_IDLE;
                    owner_d      = OWN_NONE;
                    synth_fail_d = 1'b0;
                    rr_d         = (owner_q == OWN_R0);
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    assign fwd  = (state_q == ST_REQ) || (state_q == ST_ACK);
    assign resp = (state_q == ST_RESP);

    always_comb begin
        mbus_txaddr = 32'h0;
        mbus_txdata = 32'h0;
        if (owner_q == OWN_R0) begin
            mbus_txaddr = r0_txaddr;
            mbus_txdata = r0_txdata;
        end else if (owner_q == OWN_R1) begin
            mbus_txaddr = r1_txaddr;
            mbus_txdata = r1_txdata;
        end
    end

    assign mbus_txreq      = fwd & own_req;
    assign mbus_txpend     = fwd & own_pend;
    assign mbus_txresp_ack = resp & own_resp_ack;
    assign r0_txack        = fwd & owner_q[0] & mbus_txack;
    assign r1_txack        = fwd & owner_q[1] & mbus_txack;
    assign r0_txsucc       = resp & owner_q[0] & mbus_txsucc;
    assign r1_txsucc       = resp & owner_q[1] & mbus_txsucc;
    assign r0_txfail       = resp & owner_q[0] & (mbus_txfail | synth_fail_q);
    assign r1_txfail       = resp & owner_q[1] & (mbus_txfail | synth_fail_q);
    assign arb_owner       = owner_q;
    assign arb_timeout     = timeout_q;

endmodule

// File: tb/tb_mbus_tx_arbiter.sv
// tb/tb_mbus_tx_arbiter.sv - self-checking bench for mbus_tx_arbiter
module tb_mbus_tx_arbiter;

    localparam logic [31:0] R0_ADDR = 32'h000000A0;
    localparam logic [31:0] R0_DATA = 32'hDEADBEEF;
    localparam logic [31:0] R1_ADDR = 32'h000000B0;
    localparam logic [31:0] R1_DATA = 32'h12345678;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] r0_txaddr = R0_ADDR, r0_txdata = R0_DATA;
    logic [31:0] r1_txaddr = R1_ADDR, r1_txdata = R1_DATA;
    logic        r0_txreq = 0, r0_txpend = 0, r0_txresp_ack = 0;
    logic        r1_txreq = 0, r1_txpend = 0, r1_txresp_ack = 0;
    logic        mbus_txack = 0, mbus_txsucc = 0, mbus_txfail = 0;
    logic        r0_txack, r0_txsucc, r0_txfail, r1_txack, r1_txsucc, r1_txfail;
    logic [31:0] mbus_txaddr, mbus_txdata;
    logic        mbus_txreq, mbus_txpend, mbus_txresp_ack, arb_timeout;
    logic [1:0]  arb_owner;

    logic        b_r0_txack, b_r0_txsucc, b_r0_txfail, b_r1_txack, b_r1_txsucc, b_r1_txfail;
    logic [31:0] b_mbus_txaddr, b_mbus_txdata;
    logic        b_mbus_txreq, b_mbus_txpend, b_mbus_txresp_ack, b_arb_timeout;
    logic [1:0]  b_arb_owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mbus_tx_arbiter #(.RR_EN(1), .TO_W(16), .TO_CYC(8)) u_dut (
        .clk(clk), .reset(reset),
        .r0_txaddr(r0_txaddr), .r0_txdata(r0_txdata), .r0_txreq(r0_txreq), .r0_txpend(r0_txpend),
        .r0_txack(r0_txack), .r0_txsucc(r0_txsucc), .r0_txfail(r0_txfail), .r0_txresp_ack(r0_txresp_ack),
        .r1_txaddr(r1_txaddr), .r1_txdata(r1_txdata), .r1_txreq(r1_txreq), .r1_txpend(r1_txpend),
        .r1_txack(r1_txack), .r1_txsucc(r1_txsucc), .r1_txfail(r1_txfail), .r1_txresp_ack(r1_txresp_ack),
        .mbus_txaddr(mbus_txaddr), .mbus_txdata(mbus_txdata), .mbus_txreq(mbus_txreq),
        .mbus_txpend(mbus_txpend), .mbus_txack(mbus_txack), .mbus_txsucc(mbus_txsucc),
        .mbus_txfail(mbus_txfail), .mbus_txresp_ack(mbus_txresp_ack),
        .arb_owner(arb_owner), .arb_timeout(arb_timeout)
    );

    // Fixed-priority instance fed the same stimulus; only its grant decisions are checked
    mbus_tx_arbiter #(.RR_EN(0), .TO_W(16), .TO_CYC(8)) u_dut_fp (
        .clk(clk), .reset(reset),
        .r0_txaddr(r0_txaddr), .r0_txdata(r0_txdata), .r0_txreq(r0_txreq), .r0_txpend(r0_txpend),
        .r0_txack(b_r0_txack), .r0_txsucc(b_r0_txsucc), .r0_txfail(b_r0_txfail), .r0_txresp_ack(r0_txresp_ack),
        .r1_txaddr(r1_txaddr), .r1_txdata(r1_txdata), .r1_txreq(r1_txreq), .r1_txpend(r1_txpend),
        .r1_txack(b_r1_txack), .r1_txsucc(b_r1_txsucc), .r1_txfail(b_r1_txfail), .r1_txresp_ack(r1_txresp_ack),
        .mbus_txaddr(b_mbus_txaddr), .mbus_txdata(b_mbus_txdata), .mbus_txreq(b_mbus_txreq),
        .mbus_txpend(b_mbus_txpend), .mbus_txack(mbus_txack), .mbus_txsucc(mbus_txsucc),
        .mbus_txfail(mbus_txfail), .mbus_txresp_ack(b_mbus_txresp_ack),
        .arb_owner(b_arb_owner), .arb_timeout(b_arb_timeout)
    );

    // in  = {r0q r0p, r1q r1p, ack succ fail, ra0 ra1}
    // exp = {owner, mreq mpend, a0 a1, s0 f0 s1 f1, mresp_ack}
    typedef struct packed {
        logic [8:0]  in;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl [41];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] out_vec();
        return {arb_owner, mbus_txreq, mbus_txpend, r0_txack, r1_txack,
                r0_txsucc, r0_txfail, r1_txsucc, r1_txfail, mbus_txresp_ack};
    endfunction

    function automatic logic [10:0] b_out_vec();
        return {b_arb_owner, b_mbus_txreq, b_mbus_txpend, b_r0_txack, b_r1_txack,
                b_r0_txsucc, b_r0_txfail, b_r1_txsucc, b_r1_txfail, b_mbus_txresp_ack};
    endfunction

    task automatic drive_req(input int who, input logic req, input logic pend, input logic [31:0] d);
        if (who == 0) begin
            r0_txreq = req; r0_txpend = pend; r0_txdata = d;
        end else begin
            r1_txreq = req; r1_txpend = pend; r1_txdata = d;
        end
    endtask

    task automatic clear_inputs();
        {r0_txreq, r0_txpend, r1_txreq, r1_txpend, mbus_txack, mbus_txsucc, mbus_txfail,
         r0_txresp_ack, r1_txresp_ack} = '0;
        r0_txdata = R0_DATA;
        r1_txdata = R1_DATA;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One complete transaction by requester 'who', acting as requester and as MBus
    task automatic serve(input int who, input int nw, input bit fl);
        logic [31:0] d;
        logic [1:0]  oh;
        logic [3:0]  exp_resp;
        int          cnt;
        oh = (who == 0) ? 2'b01 : 2'b10;
        for (int w = 0; w < nw; w++) begin
            d = $urandom;
            drive_req(who, 1'b1, (w < nw - 1), d);
            cnt = 0;
            #1;
            while (mbus_txreq !== 1'b1 && cnt < 20) begin
                @(negedge clk); #1; cnt++;
            end
            chk("rnd_req_seen", mbus_txreq, 1);
            chk("rnd_owner", arb_owner, oh);
            chk("rnd_data", mbus_txdata, d);
            chk("rnd_addr", mbus_txaddr, (who == 0) ? R0_ADDR : R1_ADDR);
            chk("rnd_pend", mbus_txpend, (w < nw - 1));
            @(negedge clk); mbus_txack = 1'b1; #1;
            chk("rnd_ack_routed", {r1_txack, r0_txack}, oh);
            @(negedge clk); drive_req(who, 1'b0, 1'b0, d);
            @(negedge clk); mbus_txack = 1'b0;
            @(negedge clk);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (fl) mbus_txfail = 1'b1; else mbus_txsucc = 1'b1;
        exp_resp = (who == 0) ? {2'b00, ~fl, fl} : {~fl, fl, 2'b00};
        cnt = 0;
        #1;
        while ({r1_txsucc, r1_txfail, r0_txsucc, r0_txfail} == 4'b0 && cnt < 20) begin
            @(negedge clk); #1; cnt++;
        end
        chk("rnd_resp_routed", {r1_txsucc, r1_txfail, r0_txsucc, r0_txfail}, exp_resp);
        @(negedge clk);
        if (who == 0) r0_txresp_ack = 1'b1; else r1_txresp_ack = 1'b1;
        #1;
        chk("rnd_resp_ack", mbus_txresp_ack, 1);
        @(negedge clk); mbus_txsucc = 1'b0; mbus_txfail = 1'b0;
        @(negedge clk); r0_txresp_ack = 1'b0; r1_txresp_ack = 1'b0;
        @(negedge clk); #1;
        chk("rnd_release", arb_owner, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [1:0] pend_r;
        int         ptr, win, k;

        // Single word on r0
        tbl[0]  = {9'b00_00_000_00, 11'b00_00_00_0000_0};
        tbl[1]  = {9'b10_00_000_00, 11'b00_00_00_0000_0};
        tbl[2]  = {9'b10_00_000_00, 11'b01_10_00_0000_0};
        tbl[3]  = {9'b10_00_100_00, 11'b01_10_10_0000_0};
        tbl[4]  = {9'b00_00_100_00, 11'b01_00_10_0000_0};
        tbl[5]  = {9'b00_00_000_00, 11'b01_00_00_0000_0};
        tbl[6]  = {9'b00_00_000_00, 11'b01_00_00_0000_0};
        tbl[7]  = {9'b00_00_010_00, 11'b01_00_00_0000_0};
        tbl[8]  = {9'b00_00_010_00, 11'b01_00_00_1000_0};
        tbl[9]  = {9'b00_00_010_10, 11'b01_00_00_1000_1};
        tbl[10] = {9'b00_00_000_10, 11'b01_00_00_0000_1};
        tbl[11] = {9'b00_00_000_00, 11'b01_00_00_0000_0};
        tbl[12] = {9'b00_00_000_00, 11'b00_00_00_0000_0};
        // Three-word burst on r1, r0 requesting mid-burst
        tbl[13] = {9'b00_11_000_00, 11'b00_00_00_0000_0};
        tbl[14] = {9'b00_11_000_00, 11'b10_11_00_0000_0};
        tbl[15] = {9'b00_11_100_00, 11'b10_11_01_0000_0};
        tbl[16] = {9'b00_00_100_00, 11'b10_00_01_0000_0};
        tbl[17] = {9'b10_00_000_00, 11'b10_00_00_0000_0};
        tbl[18] = {9'b10_11_000_00, 11'b10_11_00_0000_0};
        tbl[19] = {9'b10_11_100_00, 11'b10_11_01_0000_0};
        tbl[20] = {9'b10_00_100_00, 11'b10_00_01_0000_0};
        tbl[21] = {9'b10_00_000_00, 11'b10_00_00_0000_0};
        tbl[22] = {9'b10_10_000_00, 11'b10_10_00_0000_0};
        tbl[23] = {9'b10_10_100_00, 11'b10_10_01_0000_0};
        tbl[24] = {9'b10_00_100_00, 11'b10_00_01_0000_0};
        tbl[25] = {9'b10_00_000_00, 11'b10_00_00_0000_0};
        tbl[26] = {9'b10_00_010_00, 11'b10_00_00_0000_0};
        tbl[27] = {9'b10_00_010_01, 11'b10_00_00_0010_1};
        tbl[28] = {9'b10_00_000_01, 11'b10_00_00_0000_1};
        tbl[29] = {9'b10_00_000_00, 11'b10_00_00_0000_0};
        tbl[30] = {9'b10_00_000_00, 11'b00_00_00_0000_0};
        // Fail path on r0; a stray succ in ST_REQ is ignored
        tbl[31] = {9'b10_00_010_00, 11'b01_10_00_0000_0};
        tbl[32] = {9'b10_00_100_00, 11'b01_10_10_0000_0};
        tbl[33] = {9'b00_00_100_00, 11'b01_00_10_0000_0};
        tbl[34] = {9'b00_00_000_00, 11'b01_00_00_0000_0};
        tbl[35] = {9'b00_00_001_00, 11'b01_00_00_0000_0};
        tbl[36] = {9'b00_00_001_00, 11'b01_00_00_0100_0};
        tbl[37] = {9'b00_00_001_10, 11'b01_00_00_0100_1};
        tbl[38] = {9'b00_00_000_10, 11'b01_00_00_0000_1};
        tbl[39] = {9'b00_00_000_00, 11'b01_00_00_0000_0};
        tbl[40] = {9'b00_00_000_00, 11'b00_00_00_0000_0};

        // Outputs held at zero while reset is asserted
        @(negedge clk); #1;
        chk("reset_outputs", {out_vec(), arb_timeout}, 12'h0);
        chk("reset_addr_data", {mbus_txaddr, mbus_txdata}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            {r0_txreq, r0_txpend, r1_txreq, r1_txpend, mbus_txack, mbus_txsucc, mbus_txfail,
             r0_txresp_ack, r1_txresp_ack} = tbl[i].in;
            #1;
            chk($sformatf("vec%0d_outputs", i), out_vec(), tbl[i].exp);
            chk($sformatf("vec%0d_addr", i), mbus_txaddr,
                (tbl[i].exp[10:9] == 2'b01) ? R0_ADDR : (tbl[i].exp[10:9] == 2'b10) ? R1_ADDR : 32'h0);
            chk($sformatf("vec%0d_data", i), mbus_txdata,
                (tbl[i].exp[10:9] == 2'b01) ? R0_DATA : (tbl[i].exp[10:9] == 2'b10) ? R1_DATA : 32'h0);
        end

        // Watchdog: no response after the last word
        @(negedge clk); r0_txreq = 1'b1;
        @(negedge clk); mbus_txack = 1'b1;
        @(negedge clk); r0_txreq = 1'b0;
        @(negedge clk); mbus_txack = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); #1;
            chk($sformatf("wd_pulse_c%0d", c), arb_timeout, (c == 9));
            chk($sformatf("wd_fail_c%0d", c), r0_txfail, (c >= 9));
        end
        chk("wd_r1_quiet", {r1_txack, r1_txsucc, r1_txfail}, 3'b000);
        @(negedge clk); r0_txresp_ack = 1'b1; #1;
        chk("wd_fail_held", r0_txfail, 1);
        chk("wd_resp_ack", mbus_txresp_ack, 1);
        @(negedge clk); #1;
        chk("wd_fail_cleared", r0_txfail, 0);
        chk("wd_owner_kept", arb_owner, 2'b01);
        @(negedge clk); r0_txresp_ack = 1'b0;
        @(negedge clk); #1;
        chk("wd_idle", arb_owner, 2'b00);

        // Ties: round-robin vs fixed priority
        do_reset();
        @(negedge clk); r0_txreq = 1'b1; r1_txreq = 1'b1;
        @(negedge clk); #1;
        chk("tie1_rr_owner", arb_owner, 2'b01);
        chk("tie1_fp_owner", b_arb_owner, 2'b01);
        mbus_txack = 1'b1;
        @(negedge clk); r0_txreq = 1'b0;
        @(negedge clk); mbus_txack = 1'b0;
        @(negedge clk); mbus_txsucc = 1'b1;
        @(negedge clk); r0_txresp_ack = 1'b1;
        @(negedge clk); mbus_txsucc = 1'b0;
        @(negedge clk); r0_txresp_ack = 1'b0; r0_txreq = 1'b1;
        @(negedge clk); #1;
        chk("tie2_idle", arb_owner, 2'b00);
        @(negedge clk); #1;
        chk("tie2_rr_owner", arb_owner, 2'b10);
        chk("tie2_fp_owner", b_arb_owner, 2'b01);
        chk("tie2_rr_data", mbus_txdata, R1_DATA);

        // Asynchronous reset in ST_ACK, then a fresh r1 grant
        do_reset();
        @(negedge clk); r1_txreq = 1'b1;
        @(negedge clk); mbus_txack = 1'b1;
        @(negedge clk); #1;
        chk("rst_pre_owner", arb_owner, 2'b10);
        chk("rst_pre_req", {mbus_txreq, r1_txack}, 2'b11);
        reset = 1'b1;
        #1;
        chk("rst_async_outputs", {out_vec(), arb_timeout}, 12'h0);
        chk("rst_async_fp_outputs", b_out_vec(), 11'h0);
        chk("rst_async_addr_data", {mbus_txaddr, mbus_txdata}, 64'h0);
        @(negedge clk); reset = 1'b0; mbus_txack = 1'b0;
        @(negedge clk); #1;
        chk("rst_regrant_owner", arb_owner, 2'b10);
        chk("rst_regrant_req", mbus_txreq, 1);

        // Randomised traffic against a grant-order model
        do_reset();
        pend_r = 2'b00;
        ptr = 0;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend_r[r] && $urandom_range(0, 1) == 1) begin
                    pend_r[r] = 1'b1;
                    drive_req(r, 1'b1, 1'b0, $urandom);
                end
            end
            if (pend_r == 2'b00) begin
                k = $urandom_range(0, 1);
                pend_r[k] = 1'b1;
                drive_req(k, 1'b1, 1'b0, $urandom);
            end
            win = (pend_r == 2'b11) ? ptr : (pend_r[0] ? 0 : 1);
            serve(win, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
            pend_r[win] = 1'b0;
            ptr = 1 - win;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
